pwm_duty_driver: RTL and testbench
==================================

Name: pwm_duty_driver

Overview:
- Receiving end of the Nios II `po_pwm_export` PIO.
- Turns the 8-bit duty word written by software into a registered PWM waveform for an LED or motor pin.
- Duty is double-buffered: a new value takes effect only at a period boundary.
- Instantiated at top level next to the Nios II system, same clock domain.

Parameters:
- DUTY_W, 8, width of duty word and PWM counter.
- PRESC_DIV, 196, system clocks per PWM tick; at 50 MHz this gives about 1 kHz PWM. Legal range >= 1.
- RAMP_STEP, 1, max change of active duty per period; used only with PWM_RAMP_EN.

Ports:
- clk_clk  input  1  system clock.
- reset_reset_n  input  1  synchronous active-low reset.
- en_i  input  1  run enable; 0 forces output low and clears counters.
- duty_i  input  DUTY_W  requested duty, driven by `po_pwm_export`.
- pwm_o  output  1  registered PWM output.
- period_o  output  1  one-cycle strobe at each period wrap.
- duty_active_o  output  DUTY_W  duty currently in effect.

Behaviour:
- Clocking and reset:
  - Single clock; all state updates on the rising edge of clk_clk.
  - Reset is sampled synchronously: reset_reset_n=0 at an edge clears everything that cycle.
  - Reset values: pwm_o=0, period_o=0, duty_active_o=0, prescaler=0, PWM counter=0, state=OFF.
- Constants:
  - CNT_MAX = 2^DUTY_W - 2 (254 for 8 bits).
  - Period = CNT_MAX+1 = 255 ticks, so duty all-ones gives 100 % and duty 0 gives 0 %.
- Prescaler:
  - Counts 0..PRESC_DIV-1.
  - tick=1 in the cycle the count equals PRESC_DIV-1; the count then returns to 0.
  - PRESC_DIV=1 gives tick every cycle.
- PWM counter:
  - Advances on tick only, 0..CNT_MAX.
  - Wrap event = tick AND cnt==CNT_MAX; cnt then returns to 0.
- State machine:
  - OFF:
    - Prescaler and cnt held at 0; pwm_o=0.
    - duty_active loads duty_i every cycle (ramp variant: holds 0).
    - en_i=1 -> RUN next cycle, starting at cnt=0 with prescaler=0.
  - RUN:
    - pwm_o <= (cnt < duty_active), registered, so pwm_o lags the counter by 1 cycle.
    - On a wrap event:
      - period_o=1 for exactly 1 cycle.
      - duty_active <= duty_i (ramp variant: see Optional Feature).
    - duty_i changes at any other time are ignored until the next wrap.
    - en_i=0 -> OFF next cycle; pwm_o=0 in that same next cycle and counters are cleared (mid-period abort, no period_o).
- Boundary conditions:
  - duty_i=0: pwm_o stays 0 for the whole period.
  - duty_i=255: pwm_o stays 1 continuously, with no glitch across the wrap.
  - Reset asserted mid-period: next cycle all outputs are at reset values, regardless of en_i.
  - en_i and wrap event in the same cycle: en_i=0 wins, and period_o is still pulsed for that wrap.

Optional Feature:
- Macro: PWM_RAMP_EN.
- Defined:
  - At each wrap, duty_active moves toward duty_i by min(RAMP_STEP, |duty_i - duty_active|).
  - Arithmetic is DUTY_W+1 bits, saturating, with no overshoot or wrap.
  - In OFF, duty_active=0, so every enable soft-starts from 0.
- Undefined:
  - duty_active loads duty_i directly at each wrap.
  - RAMP_STEP is ignored and no ramp logic is synthesised.

Decomposition:
- Package pwm_pkg:
  - DUTY_W default.
  - State enum type {OFF, RUN}.
  - Function cnt_max(width) returning 2^width-2.
- Sub-module pwm_prescaler:
  - Parameter PRESC_DIV.
  - Ports clk_clk, reset_reset_n, clr_i, tick_o.
  - Reused later for the display-refresh timer.

Test Plan:
- Reset then en_i=1, duty_i=0, PRESC_DIV=2 -> pwm_o stays 0 for 3 full periods; period_o pulses every 510 clocks.
- duty_i=255, en_i=1 -> pwm_o=1 continuously from 1 cycle after RUN entry, including across wraps.
- duty_i=64, PRESC_DIV=2 -> each period has pwm_o high for 128 clocks and low for 382; duty_active_o=64.
- duty_i changed 64->200 mid-period -> current period keeps 128 high clocks; the next period has 400 high clocks, and duty_active_o changes in the wrap cycle.
- en_i dropped mid-period, then reset_reset_n=0 mid-period in a second run -> both cases: pwm_o=0 the next cycle, counters 0, no period_o from the abort; RUN restarts at cnt=0.
- PWM_RAMP_EN, RAMP_STEP=16, duty_i=40 -> duty_active_o steps 16, 32, 40 on successive wraps, then holds at 40.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM duty driver and its helpers.
package pwm_pkg;

  localparam int DUTY_W_DEFAULT = 8;

  typedef enum logic {
    OFF = 1'b0,
    RUN = 1'b1
  } pwm_state_e;

  // Top counter value; the period is cnt_max+1 so an all-ones duty stays high.
  function automatic int cnt_max(input int width);
    return (2 ** width) - 2;
  endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Free-running clock divider: tick_o is high in the cycle the count sits at PRESC_DIV-1.
module pwm_prescaler #(
  parameter int PRESC_DIV = 196
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESC_DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || clr_i) begin
      count <= '0;
    end else if (count == LAST) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick_o = (count == LAST);

endmodule

// File: rtl/pwm_duty_driver.sv
// Double-buffered PWM generator fed by the po_pwm_export PIO duty word.
// Define PWM_RAMP_EN to slew the active duty by at most RAMP_STEP per period.
module pwm_duty_driver
  import pwm_pkg::*;
#(
  parameter int DUTY_W    = DUTY_W_DEFAULT,
  parameter int PRESC_DIV = 196,
  parameter int RAMP_STEP = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              en_i,
  input  logic [DUTY_W-1:0] duty_i,
  output logic              pwm_o,
  output logic              period_o,
  output logic [DUTY_W-1:0] duty_active_o
);

  localparam logic [DUTY_W-1:0] CNT_MAX = DUTY_W'(cnt_max(DUTY_W));

  if (PRESC_DIV < 1 || RAMP_STEP < 0) begin : g_param_check
    $error("pwm_duty_driver: PRESC_DIV must be >= 1 and RAMP_STEP >= 0");
  end

  pwm_state_e        state;
  pwm_state_e        state_nxt;
  logic [DUTY_W-1:0] cnt;
  logic [DUTY_W-1:0] duty_nxt;
  logic              tick;
  logic              run;
  logic              wrap;
  logic              presc_clr;

  assign run       = (state == RUN);
  // Counters clear in OFF and in the RUN cycle that drops en_i, so OFF always starts from zero.
  assign presc_clr = !run || !en_i;
  assign wrap      = run && tick && (cnt == CNT_MAX);

  pwm_prescaler #(
    .PRESC_DIV(PRESC_DIV)
  ) u_prescaler (
    .clk_clk      (clk_clk),
    .reset_reset_n(reset_reset_n),
    .clr_i        (presc_clr),
    .tick_o       (tick)
  );

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      OFF:     if (en_i)  state_nxt = RUN;
      RUN:     if (!en_i) state_nxt = OFF;
      default: state_nxt = OFF;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n || presc_clr) begin
      cnt <= '0;
    end else if (wrap) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef PWM_RAMP_EN
  localparam int SW         = DUTY_W + 1;
  localparam int STEP_CLAMP = (RAMP_STEP > (2 ** DUTY_W)) ? (2 ** DUTY_W) : RAMP_STEP;
  localparam logic [DUTY_W:0] STEP = SW'(STEP_CLAMP);

  logic              up;
  logic [DUTY_W:0]   diff;
  logic [DUTY_W:0]   step_amt;
  logic [DUTY_W:0]   ramp_sum;
  logic [DUTY_W-1:0] ramp_duty;

  always_comb begin
    up        = (duty_i >= duty_active_o);
    diff      = up ? ({1'b0, duty_i} - {1'b0, duty_active_o})
                   : ({1'b0, duty_active_o} - {1'b0, duty_i});
    step_amt  = (diff < STEP) ? diff : STEP;
    ramp_sum  = up ? ({1'b0, duty_active_o} + step_amt)
                   : ({1'b0, duty_active_o} - step_amt);
    ramp_duty = ramp_sum[DUTY_W-1:0];
    if (ramp_sum[DUTY_W]) begin
      ramp_duty = up ? '1 : '0;
    end
  end

  always_comb begin
    duty_nxt = duty_active_o;
    if (!run || !en_i) begin
      duty_nxt = '0;
    end else if (wrap) begin
      duty_nxt = ramp_duty;
    end
  end
`else
  always_comb begin
    duty_nxt = duty_active_o;
    if (!run || wrap) begin
      duty_nxt = duty_i;
    end
  end
`endif

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      pwm_o         <= 1'b0;
      period_o      <= 1'b0;
      duty_active_o <= '0;
    end else begin
      pwm_o         <= run && en_i && (cnt < duty_active_o);
      period_o      <= wrap;
      duty_active_o <= duty_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_duty_driver.sv
// Scoreboard bench for pwm_duty_driver at PRESC_DIV=2; covers the PWM_RAMP_EN build when defined.
`timescale 1ns/1ps
module tb_pwm_duty_driver;

  localparam int DW     = 8;
  localparam int BUDGET = 2000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic [DW-1:0] duty;
  logic          pwm;
  logic          per;
  logic [DW-1:0] da;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string tag;
    int    exp;
  } exp_t;

  exp_t sb_q[$];

  pwm_duty_driver #(
    .DUTY_W   (DW),
    .PRESC_DIV(2),
    .RAMP_STEP(16)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .en_i         (en),
    .duty_i       (duty),
    .pwm_o        (pwm),
    .period_o     (per),
    .duty_active_o(da)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic sb_push(input string tag, input int exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] act);
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("sb_underflow", sb_q.size(), 1);
    end else begin
      e = sb_q.pop_front();
      check_val(e.tag, act, e.exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Steps at least once, then until period_o is seen or the budget runs out.
  task automatic wait_period(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (per !== 1'b1 && n < BUDGET);
  endtask

  // Called on a period_o sample; measures one period up to the next period_o sample.
  task automatic run_period(input int change_at, input logic [DW-1:0] new_duty,
                            output int high, output int len,
                            output logic [DW-1:0] da_before, output logic [DW-1:0] da_at);
    high      = 0;
    len       = 0;
    da_before = da;
    do begin
      if (pwm === 1'b1) high++;
      da_before = da;
      len++;
      if (len == change_at) duty = new_duty;
      step();
    end while (per !== 1'b1 && len < BUDGET);
    da_at = da;
  endtask

  initial begin
    int            n;
    int            hi;
    int            ln;
    int            lows;
    int            pulses;
    logic [DW-1:0] db;
    logic [DW-1:0] dat;

    rst_n = 1'b0;
    en    = 1'b0;
    duty  = '0;
    repeat (3) step();
    sb_push("rst_pwm", 0);
    sb_push("rst_period", 0);
    sb_push("rst_duty_active", 0);
    sb_pop(pwm);
    sb_pop(per);
    sb_pop(da);

`ifdef PWM_RAMP_EN
    rst_n = 1'b1;
    duty  = 8'd40;
    en    = 1'b1;
    sb_push("ramp_first_wrap_lat", 511);
    sb_push("ramp_wrap1_da", 16);
    wait_period(n);
    sb_pop(n);
    sb_pop(da);

    sb_push("ramp_p1_high", 32);
    sb_push("ramp_p1_len", 510);
    sb_push("ramp_wrap2_da", 32);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(ln);
    sb_pop(dat);

    sb_push("ramp_p2_high", 64);
    sb_push("ramp_wrap3_da", 40);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(dat);

    sb_push("ramp_p3_high", 80);
    sb_push("ramp_hold_da", 40);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(dat);

    duty = 8'd10;
    sb_push("ramp_down_high", 80);
    sb_push("ramp_down1_da", 24);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(dat);

    sb_push("ramp_down_high2", 48);
    sb_push("ramp_down2_da", 10);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(dat);

    sb_push("ramp_low_high", 20);
    sb_push("ramp_low_da", 10);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(dat);

    repeat (20) step();
    en = 1'b0;
    sb_push("ramp_off_da", 0);
    sb_push("ramp_off_pwm", 0);
    step();
    sb_pop(da);
    sb_pop(pwm);
`else
    // Zero duty: first wrap latency proves RUN starts at cnt=0, prescaler=0.
    rst_n = 1'b1;
    duty  = '0;
    en    = 1'b1;
    sb_push("zero_first_wrap_lat", 511);
    wait_period(n);
    sb_pop(n);
    for (int p = 0; p < 3; p++) begin
      sb_push($sformatf("zero_p%0d_high", p), 0);
      sb_push($sformatf("zero_p%0d_len", p), 510);
      run_period(0, '0, hi, ln, db, dat);
      sb_pop(hi);
      sb_pop(ln);
    end

    // Full duty from a fresh enable: high from the second RUN cycle, across wraps.
    en   = 1'b0;
    duty = 8'd255;
    step();
    step();
    sb_push("off_loads_255", 255);
    sb_pop(da);
    en = 1'b1;
    step();
    sb_push("full_entry_pwm", 0);
    sb_pop(pwm);
    lows   = 0;
    pulses = 0;
    for (int i = 0; i < 1100; i++) begin
      step();
      if (pwm !== 1'b1) lows++;
      if (per === 1'b1) pulses++;
    end
    sb_push("full_low_cycles", 0);
    sb_push("full_wraps", 2);
    sb_pop(lows);
    sb_pop(pulses);

    // Duty 64, then 64->200 mid-period.
    duty = 8'd64;
    wait_period(n);
    run_period(0, '0, hi, ln, db, dat);
    sb_push("d64_high", 128);
    sb_push("d64_len", 510);
    sb_push("d64_da", 64);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(ln);
    sb_pop(dat);

    sb_push("chg_cur_high", 128);
    sb_push("chg_da_before_wrap", 64);
    sb_push("chg_da_at_wrap", 200);
    run_period(100, 8'd200, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(db);
    sb_pop(dat);
    sb_push("d200_high", 400);
    sb_push("d200_len", 510);
    run_period(0, '0, hi, ln, db, dat);
    sb_pop(hi);
    sb_pop(ln);

    // en_i dropped in the wrap cycle: still one period_o, output low.
    repeat (509) step();
    en = 1'b0;
    sb_push("en_wrap_period", 1);
    sb_push("en_wrap_pwm", 0);
    step();
    sb_pop(per);
    sb_pop(pwm);
    sb_push("en_wrap_period_end", 0);
    step();
    sb_pop(per);

    duty = 8'd77;
    sb_push("off_tracks_duty", 77);
    step();
    sb_pop(da);

    // Mid-period abort via en_i, then restart from zero.
    duty = 8'd200;
    en   = 1'b1;
    repeat (100) step();
    sb_push("abort_pre_pwm", 1);
    sb_pop(pwm);
    en = 1'b0;
    sb_push("abort_pwm", 0);
    sb_push("abort_period", 0);
    step();
    sb_pop(pwm);
    sb_pop(per);
    en = 1'b1;
    sb_push("abort_restart_lat", 511);
    wait_period(n);
    sb_pop(n);

    // Reset mid-period with en_i held high.
    repeat (60) step();
    rst_n = 1'b0;
    sb_push("midrst_pwm", 0);
    sb_push("midrst_period", 0);
    sb_push("midrst_da", 0);
    step();
    sb_pop(pwm);
    sb_pop(per);
    sb_pop(da);
    rst_n = 1'b1;
    sb_push("midrst_restart_lat", 511);
    wait_period(n);
    sb_pop(n);
`endif

    check_val("sb_drain", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
